// File: rtl/sdram_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// sdram_port_arbiter_if
// Command channel between the SDRAM port arbiter and the SDRAM command/timing
// engine. Signal names are seen from the arbiter side.
//   o_cmd_valid  command presented
//   i_cmd_ready  engine accepts the command
//   o_cmd_op     00 read burst, 01 write burst, 10 auto-refresh
//   o_cmd_port   granted port (0 for refresh)
//   o_cmd_addr   burst start address (0 for refresh)
//   o_cmd_len    burst length in words (0 for refresh)
//   i_cmd_done   one-cycle pulse when the accepted command completes
// Modports: master = arbiter, slave = command engine.
// -----------------------------------------------------------------------------
interface sdram_port_arbiter_if #(
    parameter int ADDR_W = 23
);
    logic              o_cmd_valid;
    logic              i_cmd_ready;
    logic [1:0]        o_cmd_op;
    logic [1:0]        o_cmd_port;
    logic [ADDR_W-1:0] o_cmd_addr;
    logic [7:0]        o_cmd_len;
    logic              i_cmd_done;

    modport master (
        output o_cmd_valid, o_cmd_op, o_cmd_port, o_cmd_addr, o_cmd_len,
        input  i_cmd_ready, i_cmd_done
    );

    modport slave (
        input  o_cmd_valid, o_cmd_op, o_cmd_port, o_cmd_addr, o_cmd_len,
        output i_cmd_ready, i_cmd_done
    );
endinterface

// File: rtl/sdram_port_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_port_arbiter
// Schedules the shared SDRAM command engine between four frame-buffer FIFO
// ports (0=WR1, 1=WR2, 2=RD1, 3=RD2) and periodic auto-refresh. Each port owns
// a burst pointer that wraps inside [base, max). One command is in flight at a
// time: IDLE (pick) -> ISSUE (valid/ready) -> WAIT (done).
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_port_en[4]      per-port enable
//   i_load[4]         pulse: reload port pointer to its base
//   i_base, i_max     per-port region start / exclusive end (ADDR_W each)
//   i_len             per-port burst length (8 bits each)
//   i_fill            per-port FIFO used-word count (USED_W each)
//   cmd               command channel to the SDRAM engine (master side)
//   o_busy            high in ISSUE and WAIT
//   o_ref_overrun     sticky: refresh interval expired with refresh pending
// -----------------------------------------------------------------------------
module sdram_port_arbiter #(
    parameter int ADDR_W     = 23,
    parameter int USED_W     = 10,
    parameter int REF_PERIOD = 1562
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [3:0]            i_port_en,
    input  logic [3:0]            i_load,
    input  logic [4*ADDR_W-1:0]   i_base,
    input  logic [4*ADDR_W-1:0]   i_max,
    input  logic [31:0]           i_len,
    input  logic [4*USED_W-1:0]   i_fill,
    sdram_port_arbiter_if.master  cmd,
    output logic                  o_busy,
    output logic                  o_ref_overrun
);
    localparam int CNT_W = $clog2(REF_PERIOD);
    localparam int CMP_W = (USED_W > 8) ? USED_W : 8;
    localparam logic [1:0] OP_RD  = 2'b00;
    localparam logic [1:0] OP_WR  = 2'b01;
    localparam logic [1:0] OP_REF = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_ref_cnt;
    logic              r_ref_pending;
    logic [1:0]        r_rr_last;
    logic [ADDR_W-1:0] r_ptr [4];
    logic [1:0]        r_op, r_port;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_len;

    logic [7:0]        w_len  [4];
    logic [ADDR_W-1:0] w_base [4];
    logic [ADDR_W-1:0] w_max  [4];
    logic [CMP_W-1:0]  w_fill [4];
    logic [3:0]        w_elig;
    logic              w_found;
    logic [1:0]        w_gnt, w_idx;
    logic              w_hs, w_done, w_ref_wrap;
    logic [ADDR_W:0]   w_ptr_nxt;

    assign cmd.o_cmd_valid = (r_state == S_ISSUE);
    assign cmd.o_cmd_op    = r_op;
    assign cmd.o_cmd_port  = r_port;
    assign cmd.o_cmd_addr  = r_addr;
    assign cmd.o_cmd_len   = r_len;
    assign o_busy          = (r_state != S_IDLE);

    assign w_hs       = (r_state == S_ISSUE) && cmd.i_cmd_ready;
    assign w_done     = (r_state == S_WAIT) && cmd.i_cmd_done;
    assign w_ref_wrap = (r_ref_cnt == CNT_W'(REF_PERIOD - 1));

    // Per-port unpacking and eligibility: writers need a full burst in the
    // FIFO, readers need room for one.
    always_comb begin
        for (int unsigned k = 0; k < 4; k++) begin
            w_len[k]  = i_len[k*8 +: 8];
            w_base[k] = i_base[k*ADDR_W +: ADDR_W];
            w_max[k]  = i_max[k*ADDR_W +: ADDR_W];
            w_fill[k] = CMP_W'(i_fill[k*USED_W +: USED_W]);
            if (k < 2)
                w_elig[k] = i_port_en[k] && (w_len[k] != 8'd0) && (w_fill[k] >= CMP_W'(w_len[k]));
            else
                w_elig[k] = i_port_en[k] && (w_len[k] != 8'd0) && (w_fill[k] <  CMP_W'(w_len[k]));
        end
    end

    // Round-robin search starting one past the last granted port.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = r_rr_last;
        w_idx   = r_rr_last;
        for (int unsigned i = 1; i <= 4; i++) begin
            w_idx = r_rr_last + 2'(i);
            if (!w_found && w_elig[w_idx]) begin
                w_found = 1'b1;
                w_gnt   = w_idx;
            end
        end
    end

    // The latched length equals i_len at grant time; inputs are only honoured in IDLE.
    always_comb begin
        w_ptr_nxt = {1'b0, r_ptr[r_port]} + {{(ADDR_W-7){1'b0}}, r_len};
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (r_ref_pending || w_found) w_state_nxt = S_ISSUE;
            S_ISSUE: if (cmd.i_cmd_ready)          w_state_nxt = S_WAIT;
            S_WAIT:  if (cmd.i_cmd_done)           w_state_nxt = S_IDLE;
            default:                               w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ref_cnt     <= '0;
            r_ref_pending <= 1'b0;
            o_ref_overrun <= 1'b0;
            r_rr_last     <= 2'd3;
            r_op          <= '0;
            r_port        <= '0;
            r_addr        <= '0;
            r_len         <= '0;
            for (int unsigned k = 0; k < 4; k++) r_ptr[k] <= '0;
        end else begin
            // Handshake clear first; a wrap only re-arms pending when it was clear.
            if (w_hs && (r_op == OP_REF)) r_ref_pending <= 1'b0;
            if (w_ref_wrap) begin
                r_ref_cnt <= '0;
                if (r_ref_pending) o_ref_overrun <= 1'b1;
                else               r_ref_pending <= 1'b1;
            end else begin
                r_ref_cnt <= r_ref_cnt + 1'b1;
            end

            if (r_state == S_IDLE) begin
                if (r_ref_pending) begin
                    r_op   <= OP_REF;
                    r_port <= '0;
                    r_addr <= '0;
                    r_len  <= '0;
                end else if (w_found) begin
                    r_op   <= w_gnt[1] ? OP_RD : OP_WR;
                    r_port <= w_gnt;
                    r_addr <= r_ptr[w_gnt];
                    r_len  <= w_len[w_gnt];
                end
            end

            if (w_hs && (r_op != OP_REF)) r_rr_last <= r_port;

            // Load takes precedence over the completion update of the same port.
            for (int unsigned k = 0; k < 4; k++) begin
                if (i_load[k])
                    r_ptr[k] <= w_base[k];
                else if (w_done && (r_op != OP_REF) && (r_port == 2'(k)))
                    r_ptr[k] <= (w_ptr_nxt >= {1'b0, w_max[k]}) ? w_base[k] : w_ptr_nxt[ADDR_W-1:0];
            end
        end
    end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sdram_port_arbiter
// Directed bench for sdram_port_arbiter. Instance u_a uses the nominal refresh
// period (never reached within a test); instance u_b uses REF_PERIOD=20 for the
// refresh priority and overrun scenario. Both share reset and port config.
// -----------------------------------------------------------------------------
module tb_sdram_port_arbiter;
    localparam int AW = 23;
    localparam int UW = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [3:0]      port_en, load;
    logic [4*AW-1:0] base, cmax;
    logic [31:0]     len;
    logic [4*UW-1:0] fill;
    logic            busy_a, ovr_a, busy_b, ovr_b;

    int n_vec = 0;
    int n_err = 0;

    sdram_port_arbiter_if #(.ADDR_W(AW)) a_if ();
    sdram_port_arbiter_if #(.ADDR_W(AW)) b_if ();

    sdram_port_arbiter #(.ADDR_W(AW), .USED_W(UW), .REF_PERIOD(1562)) u_a (
        .i_clk(clk), .i_rst(rst), .i_port_en(port_en), .i_load(load),
        .i_base(base), .i_max(cmax), .i_len(len), .i_fill(fill),
        .cmd(a_if.master), .o_busy(busy_a), .o_ref_overrun(ovr_a)
    );

    sdram_port_arbiter #(.ADDR_W(AW), .USED_W(UW), .REF_PERIOD(20)) u_b (
        .i_clk(clk), .i_rst(rst), .i_port_en(port_en), .i_load(load),
        .i_base(base), .i_max(cmax), .i_len(len), .i_fill(fill),
        .cmd(b_if.master), .o_busy(busy_b), .o_ref_overrun(ovr_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_port(input int k, input logic [AW-1:0] b, input logic [AW-1:0] m,
                            input logic [7:0] l, input logic [UW-1:0] f);
        base[k*AW +: AW] = b;
        cmax[k*AW +: AW] = m;
        len[k*8 +: 8]    = l;
        fill[k*UW +: UW] = f;
    endtask

    // Wait (bounded) for a command on u_a, check it, accept it, complete it.
    // ld is driven on i_load in the same cycle as i_cmd_done.
    task automatic do_cmd(input string tag, input logic [1:0] op, input logic [1:0] port,
                          input logic [AW-1:0] addr, input logic [7:0] l, input logic [3:0] ld);
        int t;
        t = 0;
        while (a_if.o_cmd_valid !== 1'b1 && t < 20) begin
            tick();
            t++;
        end
        chk({tag, ":present"}, 64'(a_if.o_cmd_valid), 64'(1));
        if (a_if.o_cmd_valid === 1'b1) begin
            chk({tag, ":op_port_addr_len"},
                64'({a_if.o_cmd_op, a_if.o_cmd_port, a_if.o_cmd_addr, a_if.o_cmd_len}),
                64'({op, port, addr, l}));
            tick();
            chk({tag, ":wait_valid_busy"}, 64'({a_if.o_cmd_valid, busy_a}), 64'(2'b01));
            tick();
            tick();
            load = ld;
            a_if.i_cmd_done = 1'b1;
            tick();
            load = 4'd0;
            a_if.i_cmd_done = 1'b0;
        end
    endtask

    initial begin
        logic [1:0]    cap_op   [9];
        logic [1:0]    cap_port [9];
        logic [AW-1:0] cap_addr [9];
        logic [7:0]    cap_len  [9];
        logic [1:0]    exp_op   [9];
        logic [1:0]    exp_port [9];
        int n;
        int t;

        exp_op   = '{2'd1, 2'd1, 2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd2, 2'd0};
        exp_port = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd0, 2'd3};

        rst = 1'b1;
        port_en = '0;
        load = '0;
        base = '0;
        cmax = '0;
        len = '0;
        fill = '0;
        a_if.i_cmd_ready = 1'b0;
        a_if.i_cmd_done  = 1'b0;
        b_if.i_cmd_ready = 1'b0;
        b_if.i_cmd_done  = 1'b0;

        // Reset state
        set_port(0, 23'h0, 23'h25800, 8'h50, 10'h50);
        do_reset();
        chk("rst_valid", 64'(a_if.o_cmd_valid), 64'(0));
        chk("rst_fields", 64'({a_if.o_cmd_op, a_if.o_cmd_port, a_if.o_cmd_addr, a_if.o_cmd_len}), 64'(0));
        chk("rst_busy_ovr", 64'({busy_a, ovr_a}), 64'(0));

        // Single write port, pointer advancing by len
        a_if.i_cmd_ready = 1'b1;
        port_en = 4'b0001;
        do_cmd("t1_c0", 2'b01, 2'd0, 23'h0,  8'h50, 4'd0);
        do_cmd("t1_c1", 2'b01, 2'd0, 23'h50, 8'h50, 4'd0);
        do_cmd("t1_c2", 2'b01, 2'd0, 23'hA0, 8'h50, 4'd0);

        // Pointer wrap inside [0x100000, 0x1000A0)
        port_en = 4'b0000;
        set_port(0, 23'h100000, 23'h1000A0, 8'h50, 10'h50);
        load = 4'b0001;
        tick();
        load = 4'b0000;
        port_en = 4'b0001;
        do_cmd("t2_c0", 2'b01, 2'd0, 23'h100000, 8'h50, 4'd0);
        do_cmd("t2_c1", 2'b01, 2'd0, 23'h100050, 8'h50, 4'd0);
        do_cmd("t2_c2", 2'b01, 2'd0, 23'h100000, 8'h50, 4'd0);
        // Write boundary: fill one short of len is not eligible
        fill[0*UW +: UW] = 10'h4F;
        repeat (5) tick();
        chk("t2_wr_fill_lt_len", 64'(a_if.o_cmd_valid), 64'(0));

        // Round-robin over all four ports
        port_en = 4'b0000;
        do_reset();
        for (int k = 0; k < 4; k++)
            set_port(k, 23'(k * 'h10000), 23'(k * 'h10000 + 'h1000), 8'h10, (k < 2) ? 10'h20 : 10'h0);
        load = 4'hF;
        tick();
        load = 4'h0;
        port_en = 4'hF;
        do_cmd("t3_c0", 2'b01, 2'd0, 23'h00000, 8'h10, 4'd0);
        do_cmd("t3_c1", 2'b01, 2'd1, 23'h10000, 8'h10, 4'd0);
        do_cmd("t3_c2", 2'b00, 2'd2, 23'h20000, 8'h10, 4'd0);
        do_cmd("t3_c3", 2'b00, 2'd3, 23'h30000, 8'h10, 4'd0);
        do_cmd("t3_c4", 2'b01, 2'd0, 23'h00010, 8'h10, 4'd0);

        // Load coinciding with done wins over the pointer advance
        port_en = 4'b0100;
        base[2*AW +: AW] = 23'h7000;
        do_cmd("t5_c0", 2'b00, 2'd2, 23'h20010, 8'h10, 4'b0100);
        do_cmd("t5_c1", 2'b00, 2'd2, 23'h07000, 8'h10, 4'd0);
        // Read boundary: fill equal to len is not eligible
        fill[2*UW +: UW] = 10'h10;
        repeat (5) tick();
        chk("t5_rd_fill_eq_len", 64'(a_if.o_cmd_valid), 64'(0));

        // Refresh priority and overrun on u_b (REF_PERIOD=20)
        port_en = 4'b0000;
        fill[2*UW +: UW] = 10'h0;
        do_reset();
        b_if.i_cmd_ready = 1'b1;
        b_if.i_cmd_done  = 1'b1;
        port_en = 4'hF;
        n = 0;
        t = 0;
        while (n < 9 && t < 80) begin
            tick();
            t++;
            if (b_if.o_cmd_valid === 1'b1) begin
                cap_op[n]   = b_if.o_cmd_op;
                cap_port[n] = b_if.o_cmd_port;
                cap_addr[n] = b_if.o_cmd_addr;
                cap_len[n]  = b_if.o_cmd_len;
                n++;
            end
        end
        b_if.i_cmd_ready = 1'b0;
        chk("t4_cmd_count", 64'(n), 64'(9));
        for (int i = 0; i < n; i++)
            chk($sformatf("t4_seq%0d_op_port", i), 64'({cap_op[i], cap_port[i]}),
                64'({exp_op[i], exp_port[i]}));
        if (n > 7)
            chk("t4_ref_addr_len", 64'({cap_addr[7], cap_len[7]}), 64'(0));
        chk("t4_no_overrun_yet", 64'(ovr_b), 64'(0));
        repeat (40) tick();
        chk("t4_overrun_set", 64'(ovr_b), 64'(1));
        b_if.i_cmd_ready = 1'b1;
        repeat (10) tick();
        chk("t4_overrun_sticky", 64'(ovr_b), 64'(1));

        // Synchronous reset while a command is presented
        port_en = 4'b0000;
        b_if.i_cmd_ready = 1'b0;
        b_if.i_cmd_done  = 1'b0;
        do_reset();
        a_if.i_cmd_ready = 1'b0;
        port_en = 4'hF;
        t = 0;
        while (a_if.o_cmd_valid !== 1'b1 && t < 20) begin
            tick();
            t++;
        end
        chk("t6_issue_reached", 64'({a_if.o_cmd_valid, busy_a}), 64'(2'b11));
        rst = 1'b1;
        tick();
        chk("t6_rst_in_issue", 64'({a_if.o_cmd_valid, busy_a}), 64'(0));
        rst = 1'b0;
        a_if.i_cmd_ready = 1'b1;
        do_cmd("t6_c0", 2'b01, 2'd0, 23'h0, 8'h10, 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
